// File: rtl/uart_rom_word_loader.sv
// UART-to-ROM-loader bridge: pairs received bytes into words, buffers them in
// a small FIFO, hands each word to the loader over a 4-phase sck/ack
// handshake, echoes a checksum byte per word, and runs the load/run session.
module uart_rom_word_loader #(
    parameter int WORD_WIDTH          = 16,
    parameter int FIFO_DEPTH          = 4,
    parameter int IDLE_TIMEOUT_CYCLES = 2500000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_byte,
    input  logic                  rx_error,
    input  logic                  tx_busy,
    output logic                  tx_transmit,
    output logic [7:0]            tx_byte,
    input  logic                  finish,
    output logic                  rom_loader_load,
    output logic                  rom_loader_sck,
    output logic [WORD_WIDTH-1:0] rom_loader_data,
    input  logic                  rom_loader_ack,
    output logic                  hack_external_reset,
    output logic [15:0]           word_count,
    output logic                  overflow,
    output logic                  frame_error
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int TO_W  = (IDLE_TIMEOUT_CYCLES > 1) ? $clog2(IDLE_TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] FIFO_FULL = CNT_W'(FIFO_DEPTH);
    localparam logic [TO_W-1:0]  TO_LAST   =
        TO_W'((IDLE_TIMEOUT_CYCLES > 0) ? (IDLE_TIMEOUT_CYCLES - 1) : 0);

    typedef enum logic [1:0] {H_IDLE, H_STROBE, H_WAITLOW} hs_state_t;
    typedef enum logic {S_LOAD, S_RUN} sess_t;

    hs_state_t              hs_state_q, hs_state_d;
    sess_t                  sess_q, sess_d;
    logic                   sck_q, sck_d;
    logic [WORD_WIDTH-1:0]  data_q, data_d;
    logic [15:0]            word_count_q, word_count_d;
    logic                   overflow_q, overflow_d;
    logic                   frame_error_q, frame_error_d;
    logic                   echo_pending_q, echo_pending_d;
    logic [7:0]             echo_byte_q, echo_byte_d;
    logic                   tx_transmit_q, tx_transmit_d;
    logic [7:0]             tx_byte_q, tx_byte_d;
    logic [7:0]             hi_q, hi_d;
    logic                   byte_phase_q, byte_phase_d;
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]       fifo_count_q, fifo_count_d;
    logic                   finish_pending_q, finish_pending_d;
    logic [TO_W-1:0]        timeout_cnt_q, timeout_cnt_d;
    logic                   hack_q;

    logic [WORD_WIDTH-1:0]  fifo_mem [FIFO_DEPTH];
    logic                   fifo_push;
    logic                   fifo_pop;
    logic                   fifo_wr_en;
    logic [WORD_WIDTH-1:0]  fifo_wr_data;
    logic                   session_restart;

    // A byte arriving while the CPU runs reopens the loading session.
    assign session_restart = (sess_q == S_RUN) && rx_valid;

    // Word storage: plain write port, read is captured into the data register.
    always_ff @(posedge clk) begin
        if (fifo_wr_en) begin
            fifo_mem[wr_ptr_q] <= fifo_wr_data;
        end
    end

    // Handshake FSM, word counter and echo pending/transmit logic.
    always_comb begin
        hs_state_d     = hs_state_q;
        sck_d          = sck_q;
        data_d         = data_q;
        word_count_d   = word_count_q;
        echo_pending_d = echo_pending_q;
        echo_byte_d    = echo_byte_q;
        tx_transmit_d  = 1'b0;
        tx_byte_d      = tx_byte_q;
        fifo_pop       = 1'b0;

        if (echo_pending_q && !tx_busy) begin
            tx_transmit_d  = 1'b1;
            tx_byte_d      = echo_byte_q;
            echo_pending_d = 1'b0;
        end

        case (hs_state_q)
            H_IDLE: begin
                if ((fifo_count_q != '0) && !rom_loader_ack && (sess_q == S_LOAD)) begin
                    fifo_pop   = 1'b1;
                    data_d     = fifo_mem[rd_ptr_q];
                    sck_d      = 1'b1;
                    hs_state_d = H_STROBE;
                end
            end
            H_STROBE: begin
                if (rom_loader_ack) begin
                    sck_d = 1'b0;
                    if (word_count_q != 16'hFFFF) begin
                        word_count_d = word_count_q + 16'd1;
                    end
                    // A newer echo simply replaces one still waiting for the UART.
                    echo_pending_d = 1'b1;
                    echo_byte_d    = {data_q[WORD_WIDTH-1 -: 4], data_q[3:0]};
                    hs_state_d     = H_WAITLOW;
                end
            end
            H_WAITLOW: begin
                if (!rom_loader_ack) begin
                    hs_state_d = H_IDLE;
                end
            end
            default: begin
                hs_state_d = H_IDLE;
                sck_d      = 1'b0;
            end
        endcase

        if (session_restart) begin
            word_count_d = '0;
        end
    end

    // Byte pairing, FIFO bookkeeping, idle timeout and session FSM.
    always_comb begin
        hi_d             = hi_q;
        byte_phase_d     = byte_phase_q;
        overflow_d       = overflow_q;
        frame_error_d    = frame_error_q;
        wr_ptr_d         = wr_ptr_q;
        rd_ptr_d         = rd_ptr_q;
        fifo_count_d     = fifo_count_q;
        fifo_push        = 1'b0;
        fifo_wr_en       = 1'b0;
        fifo_wr_data     = {hi_q, rx_byte};
        sess_d           = sess_q;
        finish_pending_d = finish_pending_q;
        timeout_cnt_d    = timeout_cnt_q;

        if (sess_q == S_RUN) begin
            timeout_cnt_d = '0;
            if (rx_valid) begin
                sess_d           = S_LOAD;
                overflow_d       = 1'b0;
                frame_error_d    = 1'b0;
                finish_pending_d = 1'b0;
                hi_d             = rx_byte;
                byte_phase_d     = 1'b1;
            end
        end else begin
            if (rx_valid) begin
                if (!byte_phase_q) begin
                    hi_d         = rx_byte;
                    byte_phase_d = 1'b1;
                end else begin
                    byte_phase_d = 1'b0;
                    fifo_push    = 1'b1;
                end
            end

            if (rx_valid) begin
                timeout_cnt_d = '0;
            end else if (IDLE_TIMEOUT_CYCLES != 0) begin
                if (timeout_cnt_q == TO_LAST) begin
                    finish_pending_d = 1'b1;
                    timeout_cnt_d    = '0;
                end else begin
                    timeout_cnt_d = timeout_cnt_q + TO_W'(1);
                end
            end

            if (finish) begin
                finish_pending_d = 1'b1;
            end

            // Hold the switch to RUN off for a cycle carrying a byte so that
            // byte is never stranded in the FIFO while pops are frozen.
            if (finish_pending_q && (fifo_count_q == '0) && (hs_state_q == H_IDLE) &&
                !rom_loader_ack && !rx_valid) begin
                sess_d           = S_RUN;
                finish_pending_d = 1'b0;
                timeout_cnt_d    = '0;
                if (byte_phase_q) begin
                    byte_phase_d  = 1'b0;
                    frame_error_d = 1'b1;
                end
            end
        end

        // A framing error kills any half word, including one completing now.
        if (rx_error) begin
            byte_phase_d  = 1'b0;
            frame_error_d = 1'b1;
            fifo_push     = 1'b0;
        end

        if (fifo_push) begin
            if ((fifo_count_q == FIFO_FULL) && !fifo_pop) begin
                overflow_d = 1'b1;
            end else begin
                fifo_wr_en = 1'b1;
                wr_ptr_d   = wr_ptr_q + PTR_W'(1);
            end
        end
        if (fifo_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        fifo_count_d = fifo_count_q + {{(CNT_W-1){1'b0}}, fifo_wr_en}
                                    - {{(CNT_W-1){1'b0}}, fifo_pop};
    end

    // State register for all control and datapath flops.
    always_ff @(posedge clk) begin
        if (reset) begin
            hs_state_q       <= H_IDLE;
            sess_q           <= S_LOAD;
            sck_q            <= 1'b0;
            data_q           <= '0;
            word_count_q     <= '0;
            overflow_q       <= 1'b0;
            frame_error_q    <= 1'b0;
            echo_pending_q   <= 1'b0;
            echo_byte_q      <= '0;
            tx_transmit_q    <= 1'b0;
            tx_byte_q        <= '0;
            hi_q             <= '0;
            byte_phase_q     <= 1'b0;
            wr_ptr_q         <= '0;
            rd_ptr_q         <= '0;
            fifo_count_q     <= '0;
            finish_pending_q <= 1'b0;
            timeout_cnt_q    <= '0;
            hack_q           <= 1'b1;
        end else begin
            hs_state_q       <= hs_state_d;
            sess_q           <= sess_d;
            sck_q            <= sck_d;
            data_q           <= data_d;
            word_count_q     <= word_count_d;
            overflow_q       <= overflow_d;
            frame_error_q    <= frame_error_d;
            echo_pending_q   <= echo_pending_d;
            echo_byte_q      <= echo_byte_d;
            tx_transmit_q    <= tx_transmit_d;
            tx_byte_q        <= tx_byte_d;
            hi_q             <= hi_d;
            byte_phase_q     <= byte_phase_d;
            wr_ptr_q         <= wr_ptr_d;
            rd_ptr_q         <= rd_ptr_d;
            fifo_count_q     <= fifo_count_d;
            finish_pending_q <= finish_pending_d;
            timeout_cnt_q    <= timeout_cnt_d;
            hack_q           <= rom_loader_load;
        end
    end

    assign rom_loader_load     = (sess_q == S_LOAD);
    assign rom_loader_sck      = sck_q;
    assign rom_loader_data     = data_q;
    assign hack_external_reset = hack_q;
    assign tx_transmit         = tx_transmit_q;
    assign tx_byte             = tx_byte_q;
    assign word_count          = word_count_q;
    assign overflow            = overflow_q;
    assign frame_error         = frame_error_q;

endmodule
